// File: rtl/td4_pkg.sv
// td4_pkg - shared types and constants for the TD4 sequencer.
//   seq_state_t : sequencer FSM states
//   LOAD_*      : bit positions inside the op_decoder load vector
//   OP_W/IMM_W/INSTR_W : instruction field widths
package td4_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } seq_state_t;

  localparam int LOAD_A   = 0;
  localparam int LOAD_B   = 1;
  localparam int LOAD_OUT = 2;
  localparam int LOAD_PC  = 3;

  localparam int OP_W    = 4;
  localparam int IMM_W   = 4;
  localparam int INSTR_W = 8;

endpackage

// File: rtl/td4_pc_unit.sv
// td4_pc_unit - TD4 program counter.
//   clk, rst_n : clock, async active-low reset (pc <= RESET_PC)
//   update     : advance the PC this cycle (one pulse per retired instruction)
//   load       : take load_val instead of pc+1 (wraps mod 2**PC_W)
//   load_val   : jump target
//   pc         : registered program counter
//   self_jump  : combinational, a load whose target equals the current PC
module td4_pc_unit #(
  parameter int PC_W     = 4,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            update,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc,
  output logic            self_jump
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_W'(RESET_PC);
    end else if (update) begin
      pc <= load ? load_val : pc + PC_W'(1);
    end
  end

  assign self_jump = load && (load_val == pc);

endmodule

// File: rtl/td4_seq_ctrl.sv
// td4_seq_ctrl - instruction sequencer for the TD4 4-bit CPU.
// Owns PC (via td4_pc_unit), instruction register, carry flag and a
// saturating retired-instruction counter. Each instruction takes
// FETCH -> DECODE -> EXEC; write strobes and PC/carry/counter updates are
// registered at the end of EXEC.
//   clk, rst_n     : clock, async active-low reset
//   run_i / step_i : free-run level / single-step pulse (only seen in IDLE)
//   rom_addr_o     : ROM address (= pc), rom_data_i one cycle later
//   op_o, imm_o    : IR fields to op_decoder / ALU mux
//   c_flg_o        : registered carry to op_decoder
//   dec_load_i     : decoder load vector {PC,OUT,B,A}
//   alu_carry_i    : adder carry of the executing instruction
//   reg_we_o       : one-cycle write strobes {OUT,B,A}
//   pc_o           : current PC
//   busy_o         : instruction in flight (including the strobe cycle)
//   halted_o       : self-jump halt reached
//   instr_cnt_o    : retired instructions, saturating
// Optional build macro: TD4_SELF_LOOP_HALT_EN - a jump to its own address
// parks the FSM in HALTED until reset. Without it halted_o stays 0.
//
// state  | meaning
// IDLE   | waiting for run_i or step_i
// FETCH  | rom_addr_o = pc, ROM reads
// DECODE | IR <= rom_data_i
// EXEC   | decoder output sampled, PC/carry/counter/strobes updated
// HALTED | self-jump seen, sticky until reset
module td4_seq_ctrl
  import td4_pkg::*;
#(
  parameter int PC_W     = 4,
  parameter int CNT_W    = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic               step_i,
  output logic [PC_W-1:0]    rom_addr_o,
  input  logic [INSTR_W-1:0] rom_data_i,
  output logic [OP_W-1:0]    op_o,
  output logic [IMM_W-1:0]   imm_o,
  output logic               c_flg_o,
  input  logic [3:0]         dec_load_i,
  input  logic               alu_carry_i,
  output logic [2:0]         reg_we_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   instr_cnt_o
);

`ifdef TD4_SELF_LOOP_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  seq_state_t         state;
  logic [INSTR_W-1:0] ir;
  logic               c_flg;
  logic [CNT_W-1:0]   instr_cnt;
  logic [2:0]         reg_we;
  logic               busy;
  logic               halted;
  logic [PC_W-1:0]    pc;
  logic               self_jump;
  logic               halt_now;

  td4_pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .update    (state == EXEC),
    .load      (dec_load_i[LOAD_PC]),
    .load_val  (PC_W'(ir[IMM_W-1:0])),
    .pc        (pc),
    .self_jump (self_jump)
  );

  assign halt_now = HALT_EN && self_jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ir        <= '0;
      c_flg     <= 1'b0;
      instr_cnt <= '0;
      reg_we    <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      reg_we <= '0;
      case (state)
        IDLE: begin
          if (run_i || step_i) begin
            state <= FETCH;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        FETCH: begin
          state <= DECODE;
          busy  <= 1'b1;
        end
        DECODE: begin
          ir    <= rom_data_i;
          state <= EXEC;
          busy  <= 1'b1;
        end
        EXEC: begin
          reg_we <= dec_load_i[LOAD_OUT:LOAD_A];
          c_flg  <= alu_carry_i;
          if (~&instr_cnt) instr_cnt <= instr_cnt + CNT_W'(1);
          if (halt_now) begin
            state  <= HALTED;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            // busy stays high one more cycle to cover the registered strobe
            state  <= run_i ? FETCH : IDLE;
            busy   <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o  = pc;
  assign pc_o        = pc;
  assign op_o        = ir[INSTR_W-1:IMM_W];
  assign imm_o       = ir[IMM_W-1:0];
  assign c_flg_o     = c_flg;
  assign reg_we_o    = reg_we;
  assign busy_o      = busy;
  assign halted_o    = halted;
  assign instr_cnt_o = instr_cnt;

endmodule
